// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bus: two requesters (A = ALU, B = load) with valid/ready handshakes.
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  logic              a_valid;
  logic [ADDR_W-1:0] a_reg;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [ADDR_W-1:0] b_reg;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;

  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    output a_ready, b_ready
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file write port, with a per-register
// busy scoreboard (reserve at issue, release on committed write).

module regfile_sb_cell (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  output logic q
);
  // A reservation landing on the same edge as a release wins.
  always_ff @(posedge clk) begin
    if (rst)      q <= 1'b0;
    else if (set) q <= 1'b1;
    else if (clr) q <= 1'b0;
  end
endmodule

module regfile_write_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic                clk,
  input  logic                rst,
  regfile_write_arbiter_if.slave wb,
  input  logic                rsv_valid,
  input  logic [ADDR_W-1:0]   rsv_reg,
  output logic [NUM_REGS-1:0] busy,
  output logic                rsv_err,
  output logic                RegWrite,
  output logic [ADDR_W-1:0]   write_reg,
  output logic [DATA_W-1:0]   write_data
);
  localparam int STAGES = 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  wr_req_t req_a, req_b, req_win, wr_q;
  logic    grant_a, grant_b;
  logic    prio_b;
  logic [STAGES:0] vld_pipe;
  logic [NUM_REGS-1:0] set_vec, clr_vec;

  assign req_a = '{addr: wb.a_reg, data: wb.a_data};
  assign req_b = '{addr: wb.b_reg, data: wb.b_data};

  // prio_b=1 means A won last, so B is preferred on a tie.
  assign grant_a = !rst && wb.a_valid && (!wb.b_valid || !prio_b);
  assign grant_b = !rst && wb.b_valid && !grant_a;
  assign wb.a_ready = grant_a;
  assign wb.b_ready = grant_b;

  assign req_win     = grant_b ? req_b : req_a;
  assign vld_pipe[0] = grant_a || grant_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_b            <= 1'b0;
      vld_pipe[STAGES:1] <= '0;
      wr_q              <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (vld_pipe[0]) begin
        prio_b <= grant_a;
        wr_q   <= req_win;
      end
    end
  end

  assign RegWrite   = vld_pipe[STAGES];
  assign write_reg  = wr_q.addr;
  assign write_data = wr_q.data;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_sb
    assign set_vec[r] = rsv_valid && (rsv_reg == ADDR_W'(r));
    assign clr_vec[r] = RegWrite && (write_reg == ADDR_W'(r));
    regfile_sb_cell u_cell (
      .clk (clk),
      .rst (rst),
      .set (set_vec[r]),
      .clr (clr_vec[r]),
      .q   (busy[r])
    );
  end

  // Double reservation: flagged only when the bit is not being released this edge.
  always_ff @(posedge clk) begin
    if (rst) rsv_err <= 1'b0;
    else     rsv_err <= |(set_vec & busy & ~clr_vec);
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed scenarios plus a randomized run against a behavioural model.
module tb_regfile_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int NR = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) wb ();
  logic          rsv_valid;
  logic [AW-1:0] rsv_reg;
  logic [NR-1:0] busy;
  logic          rsv_err, RegWrite;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb         (wb),
    .rsv_valid  (rsv_valid),
    .rsv_reg    (rsv_reg),
    .busy       (busy),
    .rsv_err    (rsv_err),
    .RegWrite   (RegWrite),
    .write_reg  (write_reg),
    .write_data (write_data)
  );

  task automatic drive(input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                       input logic bv, input logic [AW-1:0] br, input logic [DW-1:0] bd,
                       input logic rv, input logic [AW-1:0] rr);
    wb.a_valid = av; wb.a_reg = ar; wb.a_data = ad;
    wb.b_valid = bv; wb.b_reg = br; wb.b_data = bd;
    rsv_valid = rv;  rsv_reg = rr;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(); tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 3'd1, 32'h11, 1'b1, 3'd2, 32'h22, 1'b1, 3'd4);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if ({wb.a_ready, wb.b_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b exp 00", {wb.a_ready, wb.b_ready}); end
      tick();
      n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite: got %b exp 0", RegWrite); end
      n_checks++; if (busy !== '0) begin n_fail++; $display("FAIL reset_busy: got %h exp 0", busy); end
      n_checks++; if ({rsv_err, write_reg, write_data} !== '0) begin n_fail++; $display("FAIL reset_regs: err %b reg %0d data %h exp 0", rsv_err, write_reg, write_data); end
    end
    rst = 1'b0; idle(); tick();
    n_checks++; if (RegWrite !== 1'b0 || busy !== '0) begin n_fail++; $display("FAIL post_reset: RegWrite %b busy %h exp 0/0", RegWrite, busy); end
  endtask

  task automatic test_single_write();
    do_reset();
    drive(1'b1, 3'd3, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, '0);
    #1;
    n_checks++; if ({wb.a_ready, wb.b_ready} !== 2'b10) begin n_fail++; $display("FAIL single_ready: got %b exp 10", {wb.a_ready, wb.b_ready}); end
    tick(); idle();
    n_checks++; if (RegWrite !== 1'b1 || write_reg !== 3'd3 || write_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_write: got %b/%0d/%h exp 1/3/deadbeef", RegWrite, write_reg, write_data); end
    tick();
    n_checks++; if (RegWrite !== 1'b0 || write_reg !== 3'd3 || write_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_hold: got %b/%0d/%h exp 0/3/deadbeef", RegWrite, write_reg, write_data); end
  endtask

  task automatic test_back_to_back();
    logic ea;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, AW'(i), 32'hA0 + i, 1'b1, AW'(i + 4), 32'hB0 + i, 1'b0, '0);
      #1;
      ea = (i % 2 == 0);
      n_checks++; if ({wb.a_ready, wb.b_ready} !== {ea, !ea}) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b exp %b", i, {wb.a_ready, wb.b_ready}, {ea, !ea}); end
      tick();
      n_checks++; if (RegWrite !== 1'b1 || write_data !== (ea ? 32'hA0 + i : 32'hB0 + i)) begin n_fail++; $display("FAIL rr_write[%0d]: got %b/%h exp 1/%h", i, RegWrite, write_data, ea ? 32'hA0 + i : 32'hB0 + i); end
    end
    idle(); tick();
    n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL rr_idle: got %b exp 0", RegWrite); end
  endtask

  task automatic test_scoreboard_release();
    do_reset();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 3'd5); tick();
    n_checks++; if (busy[5] !== 1'b1) begin n_fail++; $display("FAIL sb_set: got %b exp 1", busy[5]); end
    idle(); tick();
    drive(1'b1, 3'd5, 32'h55, 1'b0, '0, '0, 1'b0, '0); tick();
    idle();
    n_checks++; if (RegWrite !== 1'b1 || busy[5] !== 1'b1) begin n_fail++; $display("FAIL sb_pending: RegWrite %b busy5 %b exp 1/1", RegWrite, busy[5]); end
    tick();
    n_checks++; if (busy[5] !== 1'b0) begin n_fail++; $display("FAIL sb_release: got %b exp 0", busy[5]); end
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 3'd5); tick();
    drive(1'b1, 3'd5, 32'h56, 1'b0, '0, '0, 1'b0, '0); tick();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 3'd5); tick();
    n_checks++; if (busy[5] !== 1'b1 || rsv_err !== 1'b0) begin n_fail++; $display("FAIL sb_rerserve_on_commit: busy5 %b err %b exp 1/0", busy[5], rsv_err); end
    idle(); tick();
    n_checks++; if (busy[5] !== 1'b1) begin n_fail++; $display("FAIL sb_rereserve_hold: got %b exp 1", busy[5]); end
  endtask

  task automatic test_rsv_err();
    do_reset();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 3'd2); tick();
    n_checks++; if (rsv_err !== 1'b0) begin n_fail++; $display("FAIL err_first: got %b exp 0", rsv_err); end
    tick();
    n_checks++; if (busy !== 8'h04 || rsv_err !== 1'b1) begin n_fail++; $display("FAIL err_second: busy %h err %b exp 04/1", busy, rsv_err); end
    idle(); tick();
    n_checks++; if (busy !== 8'h04 || rsv_err !== 1'b0) begin n_fail++; $display("FAIL err_pulse: busy %h err %b exp 04/0", busy, rsv_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 3'd1); tick();
    drive(1'b1, 3'd1, 32'hCAFE0001, 1'b0, '0, '0, 1'b0, '0);
    #1;
    n_checks++; if (wb.a_ready !== 1'b1) begin n_fail++; $display("FAIL mid_grant: got %b exp 1", wb.a_ready); end
    tick();
    rst = 1'b1; idle(); tick();
    n_checks++; if (RegWrite !== 1'b0 || busy !== '0) begin n_fail++; $display("FAIL mid_reset: RegWrite %b busy %h exp 0/0", RegWrite, busy); end
    rst = 1'b0; tick();
    n_checks++; if (RegWrite !== 1'b0 || busy !== '0 || write_reg !== '0) begin n_fail++; $display("FAIL mid_after: RegWrite %b busy %h reg %0d exp 0/0/0", RegWrite, busy, write_reg); end
  endtask

  // Model: last grant (0 none/reset, 1 A, 2 B), committed-write pipeline, busy set per register.
  task automatic test_random();
    logic          av, bv, rv, r;
    logic [AW-1:0] ar, br, rr;
    logic [DW-1:0] ad, bd;
    int            last, win;
    logic          m_rw, m_err;
    logic [AW-1:0] m_wr;
    logic [DW-1:0] m_wd;
    logic [NR-1:0] m_busy, nb;
    do_reset();
    av = 0; bv = 0; ar = '0; br = '0; ad = '0; bd = '0;
    last = 0; m_rw = 0; m_err = 0; m_wr = '0; m_wd = '0; m_busy = '0;
    for (int n = 0; n < 400; n++) begin
      if (!av) begin av = ($urandom_range(0, 2) != 0); ar = AW'($urandom); ad = $urandom; end
      if (!bv) begin bv = ($urandom_range(0, 2) != 0); br = AW'($urandom); bd = $urandom; end
      rv = ($urandom_range(0, 3) == 0); rr = AW'($urandom);
      r  = ($urandom_range(0, 39) == 0);
      rst = r;
      drive(av, ar, ad, bv, br, bd, rv, rr);
      #1;
      if (r)              win = 0;
      else if (av && bv)  win = (last == 1) ? 2 : 1;
      else if (av)        win = 1;
      else if (bv)        win = 2;
      else                win = 0;
      n_checks++; if ({wb.a_ready, wb.b_ready} !== {win == 1, win == 2}) begin n_fail++; $display("FAIL rnd_grant[%0d]: got %b exp %b", n, {wb.a_ready, wb.b_ready}, {win == 1, win == 2}); end
      if (r) begin
        last = 0; m_rw = 0; m_err = 0; m_wr = '0; m_wd = '0; m_busy = '0;
      end else begin
        for (int k = 0; k < NR; k++)
          nb[k] = (rv && rr == k) ? 1'b1 : (m_rw && m_wr == k) ? 1'b0 : m_busy[k];
        m_err = rv && m_busy[rr] && !(m_rw && m_wr == rr);
        m_busy = nb;
        m_rw = (win != 0);
        if (win == 1) begin m_wr = ar; m_wd = ad; end
        if (win == 2) begin m_wr = br; m_wd = bd; end
        if (win != 0) last = win;
      end
      tick();
      n_checks++; if (RegWrite !== m_rw || write_reg !== m_wr || write_data !== m_wd) begin n_fail++; $display("FAIL rnd_write[%0d]: got %b/%0d/%h exp %b/%0d/%h", n, RegWrite, write_reg, write_data, m_rw, m_wr, m_wd); end
      n_checks++; if (busy !== m_busy || rsv_err !== m_err) begin n_fail++; $display("FAIL rnd_sb[%0d]: busy %h err %b exp %h/%b", n, busy, rsv_err, m_busy, m_err); end
      if (win == 1) av = 0;
      if (win == 2) bv = 0;
    end
    rst = 1'b0; idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_single_write();
    test_back_to_back();
    test_scoreboard_release();
    test_rsv_err();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
